// File: rtl/label_fetch_unit.sv
// label_fetch_unit: read-side client of the wire-label RAM.
// Waits for both labels, reads them, hands them to the garbler.
module label_fetch_unit #(
  parameter int S  = 20,
  parameter int K  = 128,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gate_valid,
  output logic          gate_ready,
  input  logic [S-1:0]  gate_addr_0,
  input  logic [S-1:0]  gate_addr_1,
  input  logic [S-1:0]  gate_tag,
  output logic          rd_req_0,
  output logic          rd_req_1,
  output logic [S-1:0]  rd_addr_0,
  output logic [S-1:0]  rd_addr_1,
  input  logic          rd_data_ready_0,
  input  logic          rd_data_ready_1,
  input  logic          stall_rd,
  input  logic [K-1:0]  rd_data_0,
  input  logic [K-1:0]  rd_data_1,
  output logic          lbl_valid,
  input  logic          lbl_ready,
  output logic [K-1:0]  lbl_0,
  output logic [K-1:0]  lbl_1,
  output logic [S-1:0]  lbl_tag,
  output logic [CW-1:0] wait_cnt,
  output logic [S-1:0]  gate_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ISSUE,
    CAPTURE,
    HOLD
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic [S-1:0] a0_q;
  logic [S-1:0] a1_q;
  logic [S-1:0] tag_q;
  logic         same_q;
  logic         wait_inc;
  logic         both_rdy;

  assign both_rdy = rd_data_ready_0 &&
                    (same_q || rd_data_ready_1);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wait_inc  = 1'b0;
    unique case (state)
      IDLE: begin
        if (gate_valid) state_nxt = WAIT;
      end
      WAIT: begin
        if (both_rdy) state_nxt = ISSUE;
        else          wait_inc  = 1'b1;
      end
      ISSUE: begin
        if (stall_rd) wait_inc  = 1'b1;
        else          state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = HOLD;
      HOLD: begin
        if (lbl_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are qualified by rst so the reset cycle never reads.
  assign gate_ready = (state == IDLE);
  assign rd_req_0   = rst && (state == ISSUE);
  assign rd_req_1   = rd_req_0 && !same_q;
  assign rd_addr_0  = a0_q;
  assign rd_addr_1  = a1_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a0_q      <= '0;
      a1_q      <= '0;
      tag_q     <= '0;
      same_q    <= 1'b0;
      lbl_0     <= '0;
      lbl_1     <= '0;
      lbl_tag   <= '0;
      lbl_valid <= 1'b0;
      wait_cnt  <= '0;
      gate_cnt  <= '0;
    end else begin
      if (state == IDLE && gate_valid) begin
        a0_q   <= gate_addr_0;
        a1_q   <= gate_addr_1;
        tag_q  <= gate_tag;
        same_q <= (gate_addr_0 == gate_addr_1);
      end
      if (wait_inc && wait_cnt != '1)
        wait_cnt <= wait_cnt + 1'b1;
      if (state == CAPTURE) begin
        lbl_0     <= rd_data_0;
        lbl_1     <= same_q ? rd_data_0 : rd_data_1;
        lbl_tag   <= tag_q;
        lbl_valid <= 1'b1;
      end
      if (state == HOLD && lbl_ready) begin
        lbl_valid <= 1'b0;
        gate_cnt  <= gate_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_label_fetch_unit.sv
// tb_label_fetch_unit: directed bench for label_fetch_unit.
// Small RAM model with per-address flags and 1-cycle read data.
module tb_label_fetch_unit;

  localparam int S  = 20;
  localparam int K  = 128;
  localparam int CW = 16;
  localparam logic [K-1:0] JUNK = {4{32'hBAD0_BAD0}};

  logic          clk;
  logic          rst;
  logic          gate_valid;
  logic          gate_ready;
  logic [S-1:0]  gate_addr_0;
  logic [S-1:0]  gate_addr_1;
  logic [S-1:0]  gate_tag;
  logic          rd_req_0;
  logic          rd_req_1;
  logic [S-1:0]  rd_addr_0;
  logic [S-1:0]  rd_addr_1;
  logic          rd_data_ready_0;
  logic          rd_data_ready_1;
  logic          stall_rd;
  logic [K-1:0]  rd_data_0;
  logic [K-1:0]  rd_data_1;
  logic          lbl_valid;
  logic          lbl_ready;
  logic [K-1:0]  lbl_0;
  logic [K-1:0]  lbl_1;
  logic [S-1:0]  lbl_tag;
  logic [CW-1:0] wait_cnt;
  logic [S-1:0]  gate_cnt;

  logic flag [16];
  logic kill1;
  int   total;
  int   bad;

  label_fetch_unit #(.S(S), .K(K), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_addr_0(gate_addr_0), .gate_addr_1(gate_addr_1),
    .gate_tag(gate_tag),
    .rd_req_0(rd_req_0), .rd_req_1(rd_req_1),
    .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
    .rd_data_ready_0(rd_data_ready_0),
    .rd_data_ready_1(rd_data_ready_1),
    .stall_rd(stall_rd),
    .rd_data_0(rd_data_0), .rd_data_1(rd_data_1),
    .lbl_valid(lbl_valid), .lbl_ready(lbl_ready),
    .lbl_0(lbl_0), .lbl_1(lbl_1), .lbl_tag(lbl_tag),
    .wait_cnt(wait_cnt), .gate_cnt(gate_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [K-1:0] lbl_of(input logic [S-1:0] a);
    return {12'h000, a, 12'hfff, ~a, 32'hA5A5_5A5A, 12'h123, a};
  endfunction

  always_comb begin
    rd_data_ready_0 = flag[rd_addr_0[3:0]];
    rd_data_ready_1 = flag[rd_addr_1[3:0]] && !kill1;
  end

  // Read data lands one cycle after an unstalled request.
  always @(posedge clk) begin
    rd_data_0 <= (rd_req_0 && !stall_rd) ? lbl_of(rd_addr_0) : JUNK;
    rd_data_1 <= (rd_req_1 && !stall_rd) ? lbl_of(rd_addr_1) : JUNK;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic send(input logic [S-1:0] a0,
                      input logic [S-1:0] a1,
                      input logic [S-1:0] tg);
    gate_addr_0 = a0;
    gate_addr_1 = a1;
    gate_tag    = tg;
    gate_valid  = 1'b1;
    tick();
    gate_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    total++;
    if (rd_req_0 !== 1'b0 || rd_req_1 !== 1'b0) begin
      bad++;
      $display("FAIL rst_req got=%b%b exp=00", rd_req_0, rd_req_1);
    end
    tick();
    rst = 1'b1;
    total++;
    if (gate_ready !== 1'b1 || lbl_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_hs got=%b%b exp=10", gate_ready, lbl_valid);
    end
    total++;
    if (lbl_0 !== '0 || lbl_1 !== '0 || lbl_tag !== '0) begin
      bad++;
      $display("FAIL rst_lbl got=%h exp=0", lbl_0);
    end
    total++;
    if (wait_cnt !== '0 || gate_cnt !== '0 || rd_addr_0 !== '0) begin
      bad++;
      $display("FAIL rst_cnt got=%h/%h exp=0/0", wait_cnt, gate_cnt);
    end
  endtask

  task automatic test_basic();
    do_reset();
    lbl_ready = 1'b1;
    send(20'd5, 20'd9, 20'h33);
    total++;
    if (rd_req_0 !== 1'b0 || gate_ready !== 1'b0) begin
      bad++;
      $display("FAIL basic_wait got=%b%b exp=00", rd_req_0, gate_ready);
    end
    tick();
    total++;
    if (rd_req_0 !== 1'b1 || rd_req_1 !== 1'b1) begin
      bad++;
      $display("FAIL basic_req got=%b%b exp=11", rd_req_0, rd_req_1);
    end
    total++;
    if (rd_addr_0 !== 20'd5 || rd_addr_1 !== 20'd9) begin
      bad++;
      $display("FAIL basic_addr got=%0d/%0d exp=5/9", rd_addr_0, rd_addr_1);
    end
    tick();
    total++;
    if (rd_req_0 !== 1'b0 || lbl_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_cap got=%b%b exp=00", rd_req_0, lbl_valid);
    end
    tick();
    total++;
    if (lbl_valid !== 1'b1 || lbl_tag !== 20'h33) begin
      bad++;
      $display("FAIL basic_vld got=%b/%h exp=1/33", lbl_valid, lbl_tag);
    end
    total++;
    if (lbl_0 !== lbl_of(20'd5) || lbl_1 !== lbl_of(20'd9)) begin
      bad++;
      $display("FAIL basic_lbl got=%h/%h exp=%h/%h", lbl_0, lbl_1,
               lbl_of(20'd5), lbl_of(20'd9));
    end
    tick();
    total++;
    if (lbl_valid !== 1'b0 || gate_cnt !== 20'd1 || wait_cnt !== '0) begin
      bad++;
      $display("FAIL basic_done got=%b/%0d/%0d exp=0/1/0",
               lbl_valid, gate_cnt, wait_cnt);
    end
  endtask

  task automatic test_wait();
    do_reset();
    lbl_ready = 1'b1;
    flag[9] = 1'b0;
    send(20'd5, 20'd9, 20'h44);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (rd_req_0 !== 1'b0 || rd_req_1 !== 1'b0) begin
        bad++;
        $display("FAIL wait_noreq%0d got=%b%b exp=00", i, rd_req_0, rd_req_1);
      end
      tick();
    end
    flag[9] = 1'b1;
    total++;
    if (wait_cnt !== 16'd7) begin
      bad++;
      $display("FAIL wait_cnt got=%0d exp=7", wait_cnt);
    end
    tick();
    total++;
    if (rd_req_0 !== 1'b1) begin
      bad++;
      $display("FAIL wait_issue got=%b exp=1", rd_req_0);
    end
    tick();
    tick();
    total++;
    if (lbl_0 !== lbl_of(20'd5) || lbl_1 !== lbl_of(20'd9) ||
        wait_cnt !== 16'd7) begin
      bad++;
      $display("FAIL wait_lbl got=%h/%h cnt=%0d exp=%h/%h cnt=7",
               lbl_0, lbl_1, wait_cnt, lbl_of(20'd5), lbl_of(20'd9));
    end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    lbl_ready = 1'b1;
    send(20'd1, 20'd2, 20'h55);
    stall_rd = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_rd = 1'b0;
      total++;
      if (rd_req_0 !== 1'b1 || rd_req_1 !== 1'b1 ||
          rd_addr_0 !== 20'd1 || rd_addr_1 !== 20'd2) begin
        bad++;
        $display("FAIL stall_hold%0d got=%b%b %0d/%0d exp=11 1/2",
                 i, rd_req_0, rd_req_1, rd_addr_0, rd_addr_1);
      end
      tick();
    end
    total++;
    if (rd_req_0 !== 1'b0) begin
      bad++;
      $display("FAIL stall_rel got=%b exp=0", rd_req_0);
    end
    tick();
    total++;
    if (lbl_0 !== lbl_of(20'd1) || lbl_1 !== lbl_of(20'd2) ||
        wait_cnt !== 16'd3) begin
      bad++;
      $display("FAIL stall_lbl got=%h/%h cnt=%0d exp=%h/%h cnt=3",
               lbl_0, lbl_1, wait_cnt, lbl_of(20'd1), lbl_of(20'd2));
    end
    tick();
  endtask

  task automatic test_same();
    do_reset();
    lbl_ready = 1'b1;
    kill1 = 1'b1;
    send(20'd12, 20'd12, 20'h66);
    tick();
    total++;
    if (rd_req_0 !== 1'b1 || rd_req_1 !== 1'b0) begin
      bad++;
      $display("FAIL same_req got=%b%b exp=10", rd_req_0, rd_req_1);
    end
    tick();
    total++;
    if (rd_req_1 !== 1'b0) begin
      bad++;
      $display("FAIL same_req1 got=%b exp=0", rd_req_1);
    end
    tick();
    total++;
    if (lbl_valid !== 1'b1 || lbl_0 !== lbl_of(20'd12) ||
        lbl_1 !== lbl_of(20'd12)) begin
      bad++;
      $display("FAIL same_lbl got=%b %h/%h exp=1 %h", lbl_valid,
               lbl_0, lbl_1, lbl_of(20'd12));
    end
    tick();
    kill1 = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    lbl_ready = 1'b0;
    send(20'd3, 20'd4, 20'h77);
    tick();
    tick();
    tick();
    gate_addr_0 = 20'd6;
    gate_addr_1 = 20'd7;
    gate_tag    = 20'h88;
    gate_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (lbl_valid !== 1'b1 || gate_ready !== 1'b0 ||
          lbl_tag !== 20'h77 || lbl_0 !== lbl_of(20'd3) ||
          lbl_1 !== lbl_of(20'd4)) begin
        bad++;
        $display("FAIL hold_stable%0d got=%b%b %h %h exp=10 77 %h",
                 i, lbl_valid, gate_ready, lbl_tag, lbl_0, lbl_of(20'd3));
      end
      tick();
    end
    lbl_ready = 1'b1;
    tick();
    total++;
    if (gate_ready !== 1'b1 || gate_cnt !== 20'd1 || lbl_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_rel got=%b %0d %b exp=1 1 0",
               gate_ready, gate_cnt, lbl_valid);
    end
    tick();
    gate_valid = 1'b0;
    tick();
    tick();
    tick();
    total++;
    if (lbl_valid !== 1'b1 || lbl_tag !== 20'h88 ||
        lbl_0 !== lbl_of(20'd6) || lbl_1 !== lbl_of(20'd7)) begin
      bad++;
      $display("FAIL hold_next got=%b %h %h exp=1 88 %h",
               lbl_valid, lbl_tag, lbl_0, lbl_of(20'd6));
    end
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    lbl_ready = 1'b1;
    send(20'd8, 20'd10, 20'h99);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (gate_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_busy%0d got=%b exp=0", i, gate_ready);
      end
      tick();
    end
    total++;
    if (gate_ready !== 1'b1 || gate_cnt !== 20'd1) begin
      bad++;
      $display("FAIL b2b_period got=%b %0d exp=1 1", gate_ready, gate_cnt);
    end
  endtask

  task automatic test_reset_mid();
    lbl_ready = 1'b1;
    flag[9] = 1'b0;
    send(20'd5, 20'd9, 20'haa);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++;
    if (gate_ready !== 1'b1 || wait_cnt !== '0 || gate_cnt !== '0 ||
        rd_addr_0 !== '0) begin
      bad++;
      $display("FAIL rstw_state got=%b %0d %0d %0d exp=1 0 0 0",
               gate_ready, wait_cnt, gate_cnt, rd_addr_0);
    end
    flag[9] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_req_0 !== 1'b0 || lbl_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstw_quiet%0d got=%b%b exp=00", i, rd_req_0, lbl_valid);
      end
      tick();
    end
    stall_rd = 1'b1;
    send(20'd5, 20'd9, 20'hbb);
    tick();
    total++;
    if (rd_req_0 !== 1'b1) begin
      bad++;
      $display("FAIL rsti_issue got=%b exp=1", rd_req_0);
    end
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (rd_req_0 !== 1'b0 || rd_req_1 !== 1'b0) begin
      bad++;
      $display("FAIL rsti_req got=%b%b exp=00", rd_req_0, rd_req_1);
    end
    tick();
    rst = 1'b1;
    stall_rd = 1'b0;
    total++;
    if (gate_ready !== 1'b1 || wait_cnt !== '0 || lbl_valid !== 1'b0) begin
      bad++;
      $display("FAIL rsti_state got=%b %0d %b exp=1 0 0",
               gate_ready, wait_cnt, lbl_valid);
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rd_req_0 !== 1'b0 || lbl_valid !== 1'b0) begin
        bad++;
        $display("FAIL rsti_quiet%0d got=%b%b exp=00", i, rd_req_0, lbl_valid);
      end
      tick();
    end
    send(20'd1, 20'd2, 20'hcc);
    tick();
    tick();
    tick();
    total++;
    if (lbl_valid !== 1'b1 || lbl_0 !== lbl_of(20'd1) ||
        lbl_1 !== lbl_of(20'd2) || lbl_tag !== 20'hcc) begin
      bad++;
      $display("FAIL rst_fresh got=%b %h %h exp=1 %h cc",
               lbl_valid, lbl_0, lbl_tag, lbl_of(20'd1));
    end
    tick();
    total++;
    if (gate_cnt !== 20'd1) begin
      bad++;
      $display("FAIL rst_fresh_cnt got=%0d exp=1", gate_cnt);
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    gate_valid  = 1'b0;
    gate_addr_0 = '0;
    gate_addr_1 = '0;
    gate_tag    = '0;
    stall_rd    = 1'b0;
    lbl_ready   = 1'b0;
    kill1       = 1'b0;
    for (int i = 0; i < 16; i++) flag[i] = 1'b1;
    test_reset();
    test_basic();
    test_wait();
    test_stall();
    test_same();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/label_fetch_unit.md
Name: label_fetch_unit

Overview:
Read-side client of the garbled-circuit wire-label dual-port RAM.
- Accepts one gate descriptor per transaction: two input-wire addresses plus a tag.
- Waits until the RAM's per-address written flags report both input labels present.
- Issues the reads on RAM ports 0/1, retrying while the RAM signals a read stall.
- Captures both K-bit labels and presents them to the garbling core over a valid/ready handshake.

Parameters:
S, 20, wire-address width (RAM depth 2**S)
K, 128, label width in bits
CW, 16, width of the saturating wait-cycle counter

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, synchronous, active-low
gate_valid  input  1  gate descriptor valid
gate_ready  output  1  unit can accept a descriptor
gate_addr_0  input  S  wire address of input label 0
gate_addr_1  input  S  wire address of input label 1
gate_tag  input  S  opaque tag (output-wire address), passed through
rd_req_0  output  1  RAM port-0 read request
rd_req_1  output  1  RAM port-1 read request
rd_addr_0  output  S  RAM port-0 read address
rd_addr_1  output  S  RAM port-1 read address
rd_data_ready_0  input  1  RAM written flag for rd_addr_0 (combinational on address)
rd_data_ready_1  input  1  RAM written flag for rd_addr_1
stall_rd  input  1  RAM cannot service reads this cycle
rd_data_0  input  K  RAM port-0 read data, one cycle after request
rd_data_1  input  K  RAM port-1 read data, one cycle after request
lbl_valid  output  1  labels valid
lbl_ready  input  1  consumer accepts labels
lbl_0  output  K  label for gate_addr_0
lbl_1  output  K  label for gate_addr_1
lbl_tag  output  S  tag of the returned gate
wait_cnt  output  CW  saturating count of cycles spent in WAIT or stalled in ISSUE
gate_cnt  output  S  count of completed gates; wraps modulo 2**S

Behaviour:
- Clock port is clk; reset port is rst, synchronous and active-low. rst==0 at a rising edge gives:
  - state=IDLE; all output registers 0 (lbl_0, lbl_1, lbl_tag, lbl_valid, wait_cnt, gate_cnt, address latches).
  - rd_req_0 and rd_req_1 are 0 during the reset cycle.
- Reset mid-operation abandons the transaction. No request is issued afterward, and no label is returned for it.
- gate_ready = (state==IDLE). rd_addr_0/1 always drive the latched addresses; they stay stable from WAIT through CAPTURE.
- same flag = (latched addr_0 == latched addr_1).
- IDLE:
  - On gate_valid, latch addresses, tag and same; go to WAIT.
  - The descriptor is accepted in the cycle gate_valid && gate_ready.
- WAIT:
  - No requests issued.
  - Advance to ISSUE when rd_data_ready_0 && (same || rd_data_ready_1); otherwise stay, with wait_cnt +1 (saturates at 2**CW-1).
- ISSUE:
  - rd_req_0=1; rd_req_1 = !same.
  - If stall_rd=1: hold requests, stay in ISSUE, wait_cnt +1.
  - If stall_rd=0: go to CAPTURE.
  - A ready flag deasserting in ISSUE is ignored; flags only ever rise between clears.
- CAPTURE:
  - Requests 0.
  - lbl_0 <= rd_data_0; lbl_1 <= same ? rd_data_0 : rd_data_1; lbl_tag <= latched tag; lbl_valid <= 1.
  - Go to HOLD.
- HOLD:
  - lbl_valid=1, outputs stable.
  - On lbl_ready: lbl_valid <= 0, gate_cnt +1, go to IDLE.
- Latency, no wait and no stall:
  - accept edge T; WAIT evaluated in T+1 → ISSUE in T+2 → CAPTURE in T+3.
  - lbl_valid high from T+4.
  - Minimum descriptor-to-descriptor period is 5 cycles.
- Simultaneous stall_rd and ready flags in WAIT: stall has no effect in WAIT; it only holds ISSUE.
- gate_cnt wraps 2**S-1 → 0. wait_cnt never wraps.
- Only one transaction is in flight at a time; gate_ready stays low until HOLD completes.

Test Plan:
- Both flags already set, addr 5/9, stall 0, lbl_ready tied 1 → rd_req_0=rd_req_1=1 for exactly one cycle (T+2); lbl_0=mem[5], lbl_1=mem[9]; lbl_valid at T+4 for 1 cycle; gate_cnt=1; wait_cnt=0.
- Flag for addr 9 set 7 cycles after accept → no rd_req while waiting; wait_cnt=7; labels correct.
- stall_rd high 3 cycles during ISSUE → rd_req held 4 cycles with constant addresses; data captured after the stall releases; wait_cnt=3.
- addr_0=addr_1=12 → rd_req_1 never asserted; lbl_0=lbl_1=mem[12]; readiness gated only on rd_data_ready_0.
- lbl_ready low 10 cycles in HOLD → lbl_valid, lbl_0, lbl_1, lbl_tag stable; gate_ready low throughout; accepts next gate after release.
- rst=0 asserted during WAIT, then during ISSUE → next edge IDLE; rd_req=0; lbl_valid=0; all counters 0; a fresh descriptor completes normally.
